// File: rtl/router_arb_pkg.sv
// Shared types, default parameters and helpers for router_port_arbiter.
package router_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_IN  = 4;
    localparam int DEF_NUM_OUT = 3;
    localparam int DEF_CREDITS = 4;

    // Pointer position just past a grant, wrapping over n requesters.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first candidate at or after ptr, with wrap.
module rr_arbiter
    import router_arb_pkg::*;
#(
    parameter int  NUM_IN = DEF_NUM_IN,
    localparam int SRC_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] cand,
    input  logic [SRC_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SRC_W-1:0]  gnt_idx
);

    logic [SRC_W-1:0] idx;

    // Scan from the far end back towards ptr so the last hit is the nearest one.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = SRC_W'((int'(ptr) + k) % NUM_IN);
            if (cand[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/router_port_arbiter.sv
// Per-output packet arbiter with round-robin grant, wormhole lock and credit gating.
// Optional ROUTER_ARB_ERR_EN adds err_flag and sinks invalid-destination requests.
module router_port_arbiter
    import router_arb_pkg::*;
#(
    parameter int  NUM_IN  = DEF_NUM_IN,
    parameter int  NUM_OUT = DEF_NUM_OUT,
    parameter int  CREDITS = DEF_CREDITS,
    localparam int SRC_W   = $clog2(NUM_IN),
    localparam int DEST_W  = $clog2(NUM_OUT),
    localparam int CRD_W   = $clog2(CREDITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN-1:0]         req_valid,
    input  logic [NUM_IN*DEST_W-1:0]  req_dest,
    input  logic [NUM_IN-1:0]         req_tail,
    output logic [NUM_IN-1:0]         req_ready,
    output logic [NUM_OUT-1:0]        out_valid,
    output logic [NUM_OUT*SRC_W-1:0]  out_src,
    output logic [NUM_OUT-1:0]        out_tail,
    output logic [NUM_OUT-1:0]        out_busy,
    input  logic [NUM_OUT-1:0]        credit_return
`ifdef ROUTER_ARB_ERR_EN
    ,
    output logic                      err_flag
`endif
);

    logic [NUM_OUT-1:0][NUM_IN-1:0] rdy_by_out;
`ifdef ROUTER_ARB_ERR_EN
    logic [NUM_OUT-1:0] ovf;
`endif

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        arb_state_t        state_q, state_d;
        logic [SRC_W-1:0]  src_q, src_d;
        logic [SRC_W-1:0]  ptr_q, ptr_d;
        logic [CRD_W-1:0]  crd_q, crd_d;
        logic [NUM_IN-1:0] cand;
        logic              gnt_valid;
        logic [SRC_W-1:0]  gnt_idx;
        logic              xfer;

        always_comb begin
            cand = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cand[i] = req_valid[i] && (req_dest[i*DEST_W +: DEST_W] == DEST_W'(o));
            end
        end

        rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
            .cand      (cand),
            .ptr       (ptr_q),
            .gnt_valid (gnt_valid),
            .gnt_idx   (gnt_idx)
        );

        always_comb begin
            state_d = state_q;
            src_d   = src_q;
            ptr_d   = ptr_q;
            crd_d   = crd_q;
            xfer    = (state_q == ARB_LOCKED) && req_valid[src_q] && (crd_q != '0);
            case (state_q)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        state_d = ARB_LOCKED;
                        src_d   = gnt_idx;
                        ptr_d   = SRC_W'(rr_next(int'(gnt_idx), NUM_IN));
                    end
                end
                ARB_LOCKED: begin
                    if (xfer && req_tail[src_q]) state_d = ARB_IDLE;
                end
            endcase
            // A transfer and a return in the same cycle cancel out.
            if (xfer && !credit_return[o]) begin
                crd_d = crd_q - 1'b1;
            end else if (!xfer && credit_return[o] && (crd_q != CRD_W'(CREDITS))) begin
                crd_d = crd_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ARB_IDLE;
                src_q   <= '0;
                ptr_q   <= '0;
                crd_q   <= CRD_W'(CREDITS);
            end else begin
                state_q <= state_d;
                src_q   <= src_d;
                ptr_q   <= ptr_d;
                crd_q   <= crd_d;
            end
        end

        assign out_valid[o]                = xfer;
        assign out_tail[o]                 = xfer && req_tail[src_q];
        assign out_busy[o]                 = (state_q == ARB_LOCKED);
        assign out_src[o*SRC_W +: SRC_W]   = src_q;
        assign rdy_by_out[o]               = xfer ? (NUM_IN'(1) << src_q) : '0;
`ifdef ROUTER_ARB_ERR_EN
        assign ovf[o] = credit_return[o] && !xfer && (crd_q == CRD_W'(CREDITS));
`endif
    end

`ifdef ROUTER_ARB_ERR_EN
    logic [NUM_IN-1:0] bad_dest;
    logic              err_q, err_d;

    always_comb begin
        bad_dest = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            bad_dest[i] = int'(req_dest[i*DEST_W +: DEST_W]) >= NUM_OUT;
        end
        err_d = err_q || (|(req_valid & bad_dest)) || (|ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_flag = err_q;
`endif

    // Each input targets one output, so OR-ing the per-output grants never collides.
    always_comb begin
        req_ready = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            req_ready = req_ready | rdy_by_out[o];
        end
`ifdef ROUTER_ARB_ERR_EN
        req_ready = req_ready | (req_valid & bad_dest);
`endif
    end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Bench for router_port_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_router_port_arbiter;
    localparam int NI = 4;
    localparam int NO = 3;
    localparam int CR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NI-1:0]   req_valid, req_tail, req_ready;
    logic [NI*2-1:0] req_dest;
    logic [NO-1:0]   out_valid, out_tail, out_busy, credit_return;
    logic [NO*2-1:0] out_src;
`ifdef ROUTER_ARB_ERR_EN
    logic            err_flag;
`endif

    int checks = 0;
    int errors = 0;

    router_port_arbiter #(.NUM_IN(NI), .NUM_OUT(NO), .CREDITS(CR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_dest      (req_dest),
        .req_tail      (req_tail),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_src       (out_src),
        .out_tail      (out_tail),
        .out_busy      (out_busy),
        .credit_return (credit_return)
`ifdef ROUTER_ARB_ERR_EN
        , .err_flag    (err_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per output a lock owner, a next-search position and a credit count.
    bit m_lock[NO];
    int m_own[NO], m_ptr[NO], m_crd[NO];
    bit m_err;
    bit n_lock[NO];
    int n_own[NO], n_ptr[NO], n_crd[NO];
    bit n_err;
    bit evald;
    logic [NO-1:0]   e_valid, e_tail, e_busy;
    logic [NI-1:0]   e_ready;
    logic [NO*2-1:0] e_src;

    function automatic int dest_of(input int i);
        return int'(req_dest[i*2 +: 2]);
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = 0; m_crd[o] = CR;
        end
        m_err = 0; evald = 0; e_ready = '0;
    endtask

    task automatic model_eval();
        e_valid = '0; e_tail = '0; e_busy = '0; e_ready = '0; e_src = '0;
        n_err = m_err;
        for (int o = 0; o < NO; o++) begin
            n_lock[o] = m_lock[o]; n_own[o] = m_own[o]; n_ptr[o] = m_ptr[o];
            e_src[o*2 +: 2] = 2'(m_own[o]);
            if (m_lock[o]) begin
                int s = m_own[o];
                e_busy[o] = 1'b1;
                if (req_valid[s] && m_crd[o] > 0) begin
                    e_valid[o] = 1'b1;
                    e_ready[s] = 1'b1;
                    if (req_tail[s]) begin
                        e_tail[o] = 1'b1;
                        n_lock[o] = 0;
                    end
                end
            end else begin
                bit found = 0;
                for (int k = 0; k < NI; k++) begin
                    int i = (m_ptr[o] + k) % NI;
                    if (!found && req_valid[i] && dest_of(i) == o) begin
                        found = 1; n_lock[o] = 1; n_own[o] = i; n_ptr[o] = (i + 1) % NI;
                    end
                end
            end
            n_crd[o] = m_crd[o] - int'(e_valid[o]) + int'(credit_return[o]);
            if (n_crd[o] > CR) begin
                n_crd[o] = CR;
                n_err = 1;
            end
        end
`ifdef ROUTER_ARB_ERR_EN
        for (int i = 0; i < NI; i++) begin
            if (req_valid[i] && dest_of(i) >= NO) begin
                e_ready[i] = 1'b1;
                n_err = 1;
            end
        end
`else
        n_err = 0;
`endif
        evald = 1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", 32'(out_busy), 0);
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_src", 32'(out_src), 0);
        end else begin
            model_eval();
            chk("valid", 32'(out_valid), 32'(e_valid));
            chk("tail", 32'(out_tail), 32'(e_tail));
            chk("busy", 32'(out_busy), 32'(e_busy));
            chk("ready", 32'(req_ready), 32'(e_ready));
            chk("src", 32'(out_src), 32'(e_src));
`ifdef ROUTER_ARB_ERR_EN
            chk("err", 32'(err_flag), 32'(m_err));
`endif
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (evald) begin
            m_lock = n_lock; m_own = n_own; m_ptr = n_ptr; m_crd = n_crd; m_err = n_err;
            evald = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic at_sample();
        @(negedge clk); #1;
    endtask

    task automatic set_req(input int i, input int d, input logic v, input logic t);
        req_valid[i] = v; req_tail[i] = t; req_dest[i*2 +: 2] = 2'(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_tail = '0; req_dest = '0; credit_return = '0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    int rr_seen[$];
    int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
    logic [9:0] cs_rdy = 10'b1100011110;
    int rem[NI];
    logic [NI-1:0] xfer_seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_tail = '0; req_dest = '0; credit_return = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic grant: input 2, 3 flits to output 1
        do_reset();
        set_req(2, 1, 1'b1, 1'b0);
        at_sample(); chk("bg_c0_busy", 32'(out_busy), 0); next_cycle();
        at_sample();
        chk("bg_c1_busy", 32'(out_busy), 32'b010);
        chk("bg_c1_valid", 32'(out_valid), 32'b010);
        chk("bg_c1_src", 32'(out_src[3:2]), 2);
        chk("bg_c1_ready", 32'(req_ready), 32'b0100);
        next_cycle();
        at_sample(); chk("bg_c2_valid", 32'(out_valid), 32'b010); chk("bg_c2_tail", 32'(out_tail), 0);
        next_cycle(); set_req(2, 1, 1'b1, 1'b1);
        at_sample(); chk("bg_c3_tail", 32'(out_tail), 32'b010);
        next_cycle(); set_req(2, 1, 1'b0, 1'b0);
        at_sample(); chk("bg_c4_busy", 32'(out_busy), 0); chk("bg_model_crd", 32'(m_crd[1]), 1);
        next_cycle();

        // Round-robin: inputs 0,1,3 single-flit packets to output 0
        do_reset();
        set_req(0, 0, 1'b1, 1'b1); set_req(1, 0, 1'b1, 1'b1); set_req(3, 0, 1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            credit_return[0] = (c % 2 == 1);
            at_sample();
            chk("rr_busy", 32'(out_busy[0]), 32'(c % 2));
            if (out_valid[0]) rr_seen.push_back(int'(out_src[1:0]));
            next_cycle();
        end
        credit_return = '0;
        chk("rr_count", 32'(rr_seen.size()), 6);
        for (int k = 0; k < 6 && k < rr_seen.size(); k++) chk("rr_order", 32'(rr_seen[k]), 32'(rr_exp[k]));

        // Credit stall: input 0, 6 flits to output 2, returns only in cycles 7 and 8
        do_reset();
        for (int c = 0; c < 10; c++) begin
            set_req(0, 2, 1'b1, c == 9);
            credit_return[2] = (c == 7 || c == 8);
            at_sample();
            chk("cs_ready", 32'(req_ready[0]), 32'(cs_rdy[c]));
            next_cycle();
        end
        set_req(0, 2, 1'b0, 1'b0); credit_return = '0;
        at_sample(); chk("cs_idle", 32'(out_busy), 0); chk("cs_model_crd", 32'(m_crd[2]), 0);
        next_cycle();

        // Parallel outputs
        do_reset();
        set_req(0, 0, 1'b1, 1'b1); set_req(1, 1, 1'b1, 1'b1); set_req(2, 2, 1'b1, 1'b1);
        at_sample(); chk("par_c0_valid", 32'(out_valid), 0); next_cycle();
        at_sample(); chk("par_c1_valid", 32'(out_valid), 32'b111); chk("par_c1_ready", 32'(req_ready), 32'b0111);
        next_cycle(); req_valid = '0;

        // Reset mid-packet: input 1, 4 flits to output 0, reset during flit 2
        do_reset();
        set_req(1, 0, 1'b1, 1'b0);
        next_cycle();
        at_sample(); chk("rm_c1_ready", 32'(req_ready), 32'b0010); next_cycle();
        #2 rst_n = 1'b0;
        #1 chk("rm_async_busy", 32'(out_busy), 0); chk("rm_async_ready", 32'(req_ready), 0);
        next_cycle(); rst_n = 1'b1;
        at_sample(); chk("rm_r0_ready", 32'(req_ready), 0); next_cycle();
        at_sample(); chk("rm_r1_ready", 32'(req_ready), 32'b0010); chk("rm_r1_busy", 32'(out_busy), 32'b001);
        next_cycle();
        at_sample(); next_cycle(); set_req(1, 0, 1'b1, 1'b1);
        at_sample(); chk("rm_tail", 32'(out_tail), 32'b001); next_cycle(); set_req(1, 0, 1'b0, 1'b0);
        at_sample(); chk("rm_model_crd", 32'(m_crd[0]), 1); next_cycle();

        // Invalid destination and credit overflow
        do_reset();
        set_req(3, 3, 1'b1, 1'b0);
`ifdef ROUTER_ARB_ERR_EN
        at_sample(); chk("err_sink_ready", 32'(req_ready[3]), 1); chk("err_c0", 32'(err_flag), 0);
        next_cycle(); set_req(3, 3, 1'b0, 1'b0);
        at_sample(); chk("err_set", 32'(err_flag), 1); next_cycle();
        at_sample(); chk("err_sticky", 32'(err_flag), 1); next_cycle();
        do_reset();
        at_sample(); chk("err_cleared", 32'(err_flag), 0);
        next_cycle(); credit_return[0] = 1'b1;
        next_cycle(); credit_return[0] = 1'b0;
        at_sample(); chk("err_overflow", 32'(err_flag), 1); next_cycle();
`else
        for (int c = 0; c < 100; c++) begin
            at_sample(); chk("bad_dest_stall", 32'(req_ready[3]), 0); next_cycle();
        end
`endif

        // Randomized traffic with occasional reset
        do_reset();
        for (int i = 0; i < NI; i++) rem[i] = 0;
        xfer_seen = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (xfer_seen[i] && rem[i] > 0) rem[i]--;
                if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
                    int d = $urandom_range(0, NO - 1);
`ifdef ROUTER_ARB_ERR_EN
                    if ($urandom_range(0, 15) == 0) d = 3;
`endif
                    rem[i] = $urandom_range(1, 4);
                    req_dest[i*2 +: 2] = 2'(d);
                end
                req_valid[i] = (rem[i] > 0) && ($urandom_range(0, 3) != 0);
                req_tail[i]  = (rem[i] == 1);
            end
            for (int o = 0; o < NO; o++) credit_return[o] = ($urandom_range(0, 2) == 0);
            if (cyc % 700 == 350) rst_n = 1'b0;
            else rst_n = 1'b1;
            at_sample();
            xfer_seen = rst_n ? e_ready : '0;
            next_cycle();
        end
        rst_n = 1'b1;
        req_valid = '0;
        credit_return = '0;
        at_sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
